// File: rtl/debounce_edge.sv
// Purpose: debounce a synchronised input bit into a clean level, rise/fall strobes and a rising-edge count.
// Latency: Level/Rise/Fall appear STABLE_CYCLES edges after Din settles on a new value; all outputs are registered.
// Backpressure: none; Din is sampled every cycle and strobes are single-cycle, non-stallable pulses.
module debounce_edge #(
    parameter int STABLE_CYCLES = 1000,
    parameter int CNT_W         = 16,
    parameter int EVT_W         = 8
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Din,
    input  logic             Clear,
    output logic             Level,
    output logic             Rise,
    output logic             Fall,
    output logic             Busy,
    output logic [EVT_W-1:0] Count
);

    // Sample index at which a candidate value has been seen STABLE_CYCLES times in a row.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_LOW    = 2'd0,
        S_CHK_HI = 2'd1,
        S_HIGH   = 2'd2,
        S_CHK_LO = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             rise_nxt;
    logic             fall_nxt;
    logic             level_nxt;
    logic             busy_nxt;
    logic [EVT_W-1:0] count_nxt;

    // Next-state, candidate counter and strobe decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            S_LOW: begin
                if (Din) begin
                    state_nxt = S_CHK_HI;
                    cnt_nxt   = CNT_W'(1);
                end else begin
                    cnt_nxt   = '0;
                end
            end
            S_CHK_HI: begin
                if (!Din) begin
                    // Glitch: drop the candidate silently.
                    state_nxt = S_LOW;
                    cnt_nxt   = '0;
                end else if (cnt == LAST_CNT) begin
                    state_nxt = S_HIGH;
                    cnt_nxt   = '0;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt   = cnt + CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (!Din) begin
                    state_nxt = S_CHK_LO;
                    cnt_nxt   = CNT_W'(1);
                end else begin
                    cnt_nxt   = '0;
                end
            end
            S_CHK_LO: begin
                if (Din) begin
                    state_nxt = S_HIGH;
                    cnt_nxt   = '0;
                end else if (cnt == LAST_CNT) begin
                    state_nxt = S_LOW;
                    cnt_nxt   = '0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt   = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = S_LOW;
                cnt_nxt   = '0;
            end
        endcase

        // Level and Busy are registered decodes of the state being entered.
        level_nxt = (state_nxt == S_HIGH) || (state_nxt == S_CHK_LO);
        busy_nxt  = (state_nxt == S_CHK_HI) || (state_nxt == S_CHK_LO);

        // Clear wins over a simultaneous accepted rise.
        count_nxt = Count;
        if (Clear) begin
            count_nxt = '0;
        end else if (rise_nxt) begin
            count_nxt = Count + EVT_W'(1);
        end
    end

    // State, counter and registered outputs; reset discards any partial qualification.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= S_LOW;
            cnt   <= '0;
            Level <= 1'b0;
            Rise  <= 1'b0;
            Fall  <= 1'b0;
            Busy  <= 1'b0;
            Count <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            Level <= level_nxt;
            Rise  <= rise_nxt;
            Fall  <= fall_nxt;
            Busy  <= busy_nxt;
            Count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_debounce_edge.sv
// Purpose: randomized and directed stimulus for debounce_edge checked by a queue-based scoreboard.
// Latency: expected outputs are queued at each input drive and compared one cycle later.
// Backpressure: none; the monitor checks every cycle and on asynchronous reset.
module tb_debounce_edge;

    localparam int SC = 4;
    localparam int CW = 3;
    localparam int EW = 8;

    logic          Clock = 1'b0;
    logic          Resetn;
    logic          Din;
    logic          Clear;
    logic          Level;
    logic          Rise;
    logic          Fall;
    logic          Busy;
    logic [EW-1:0] Count;

    typedef struct packed {
        logic          lvl;
        logic          rise;
        logic          fall;
        logic          busy;
        logic [EW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: the level flips once the input has disagreed with it
    // for SC consecutive samples; any agreeing sample resets that run.
    logic          m_lvl = 1'b0;
    int            m_run = 0;
    logic [EW-1:0] m_cnt = '0;

    debounce_edge #(
        .STABLE_CYCLES(SC),
        .CNT_W        (CW),
        .EVT_W        (EW)
    ) dut (
        .Clock (Clock),
        .Resetn(Resetn),
        .Din   (Din),
        .Clear (Clear),
        .Level (Level),
        .Rise  (Rise),
        .Fall  (Fall),
        .Busy  (Busy),
        .Count (Count)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // One clock of stimulus; the expected post-edge outputs go into the scoreboard.
    task automatic cycle(input logic din, input logic clr, input logic rstn);
        exp_t e;
        @(negedge Clock);
        Din    = din;
        Clear  = clr;
        Resetn = rstn;
        e      = '0;
        if (!rstn) begin
            m_lvl = 1'b0;
            m_run = 0;
            m_cnt = '0;
        end else begin
            if (din != m_lvl) m_run++;
            else              m_run = 0;
            if (m_run == SC) begin
                m_lvl  = din;
                m_run  = 0;
                e.rise = din;
                e.fall = !din;
            end
            if (clr)         m_cnt = '0;
            else if (e.rise) m_cnt = m_cnt + 8'd1;
        end
        e.lvl  = m_lvl;
        e.busy = (m_run != 0);
        e.cnt  = m_cnt;
        exp_q.push_back(e);
    endtask

    // Assert reset between clock edges; outputs must clear without waiting for a clock.
    task automatic async_reset();
        @(posedge Clock);
        #3;
        m_lvl = 1'b0;
        m_run = 0;
        m_cnt = '0;
        exp_q.push_back(exp_t'(0));
        Resetn = 1'b0;
    endtask

    // Monitor: compare after every clock edge and right after any reset assertion.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clock or negedge Resetn);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("level", EW'(Level), EW'(e.lvl));
                chk("rise",  EW'(Rise),  EW'(e.rise));
                chk("fall",  EW'(Fall),  EW'(e.fall));
                chk("busy",  EW'(Busy),  EW'(e.busy));
                chk("count", Count,      e.cnt);
            end
        end
    end

    initial begin
        int used;
        Resetn = 1'b0;
        Din    = 1'b1;
        Clear  = 1'b0;

        // Reset held with Din=1, then release with Din=1: first rise qualifies immediately.
        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        repeat (6) cycle(1'b1, 1'b0, 1'b1);

        // Clean fall, rise and fall with long holds.
        cycle(1'b1, 1'b1, 1'b1);
        repeat (10) cycle(1'b0, 1'b0, 1'b1);
        repeat (10) cycle(1'b1, 1'b0, 1'b1);
        repeat (10) cycle(1'b0, 1'b0, 1'b1);

        // Glitch rejection: runs shorter than SC never commit.
        repeat (3) cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        repeat (3) cycle(1'b1, 1'b0, 1'b1);
        repeat (5) cycle(1'b0, 1'b0, 1'b1);

        // 256 accepted rises to wrap Count through 255 -> 0.
        for (int i = 0; i < 256; i++) begin
            repeat (SC) cycle(1'b1, 1'b0, 1'b1);
            repeat (SC) cycle(1'b0, 1'b0, 1'b1);
        end

        // Clear coinciding with the committing edge of a rise.
        repeat (SC) cycle(1'b1, 1'b0, 1'b1);
        repeat (SC) cycle(1'b0, 1'b0, 1'b1);
        repeat (SC - 1) cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        repeat (3) cycle(1'b1, 1'b0, 1'b1);

        // Reset mid fall-qualification with two low samples seen.
        repeat (2) cycle(1'b0, 1'b0, 1'b1);
        async_reset();
        repeat (2) cycle(1'b0, 1'b0, 1'b0);
        repeat (6) cycle(1'b0, 1'b0, 1'b1);

        // Bounce burst followed by a steady high.
        for (int i = 0; i < 20; i++) cycle(1'(i % 2 == 0), 1'b0, 1'b1);
        repeat (8) cycle(1'b1, 1'b0, 1'b1);

        // Randomized runs around the qualification length, with sporadic Clear.
        used = 0;
        while (used < 1500) begin
            logic v;
            int   len;
            v   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 2 * SC);
            for (int i = 0; i < len; i++) cycle(v, 1'($urandom_range(0, 31) == 0), 1'b1);
            used += len;
        end

        // One more asynchronous reset during random-like activity, then recover.
        repeat (SC + 1) cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        async_reset();
        cycle(1'b1, 1'b0, 1'b0);
        repeat (SC + 2) cycle(1'b1, 1'b0, 1'b1);

        repeat (2) @(posedge Clock);
        #2;
        chk("sb_drain", EW'(exp_q.size()), EW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/debounce_edge.md
# debounce_edge

Downstream consumer of the two-flop input synchroniser. It takes the synchronised bit (the second flop's output) and filters out glitches and bounce. It produces a clean debounced level, single-cycle rise/fall strobes and a wrapping count of accepted rising edges. It sits between the synchroniser and any control logic that needs clean button/switch events.

## Interface
- STABLE_CYCLES, 1000: consecutive samples of a new value required before Level changes; legal range 2 to 2^CNT_W-1
- CNT_W, 16: width of the internal stability counter
- EVT_W, 8: width of the Count output
- Clock  in  1  single clock; all logic on posedge
- Resetn  in  1  reset, asynchronous and active-low
- Din  in  1  synchronised input bit from the synchroniser's second stage; already in the Clock domain
- Clear  in  1  synchronous clear of Count
- Level  out  1  debounced level
- Rise  out  1  one-cycle strobe when Level goes 0->1
- Fall  out  1  one-cycle strobe when Level goes 1->0
- Busy  out  1  high while a candidate transition is being qualified
- Count  out  EVT_W  number of accepted rising edges, modulo 2^EVT_W

## Operation
- Four-state FSM: S_LOW (Level=0 stable), S_CHK_HI (qualifying 0->1), S_HIGH (Level=1 stable), S_CHK_LO (qualifying 1->0).
- Internal counter cnt, CNT_W bits, counts consecutive samples of the candidate value.
- **S_LOW**
  - Din=1 -> S_CHK_HI, cnt=1.
  - Din=0 -> stay, cnt=0.
- **S_CHK_HI**
  - Din=0 -> S_LOW, cnt=0. A glitch is discarded with no strobe.
  - Din=1 and cnt==STABLE_CYCLES-1 -> S_HIGH, Level=1, Rise=1, cnt=0.
  - Din=1 otherwise -> cnt=cnt+1.
- **S_HIGH and S_CHK_LO** mirror S_LOW and S_CHK_HI with Din inverted. Commit gives Level=0 and Fall=1.
- **Busy** = 1 exactly when the state is S_CHK_HI or S_CHK_LO. It is a registered decode of the state.
- **Rise and Fall**
  - Registered; high for exactly one cycle, on the cycle after the committing edge.
  - Never both high in the same cycle.
- **Count**
  - Increments by 1 at the same edge that asserts Rise.
  - Wraps from 2^EVT_W-1 to 0.
  - Clear=1 forces Count=0 at the next edge. Clear has priority over a simultaneous increment, so the result is 0 and that edge is lost.
- **cnt** never exceeds STABLE_CYCLES-1, so there is no counter wrap.
- **Reset (Resetn=0, any time, including mid-qualification)**
  - Immediately: state=S_LOW, cnt=0, Level=0, Rise=0, Fall=0, Busy=0, Count=0.
  - Any partially qualified transition is discarded.

## Timing
- Din is sampled at every posedge.
- Sampling Din=1 at edges k through k+STABLE_CYCLES-1 (from S_LOW) makes Level=1 and Rise=1 visible after edge k+STABLE_CYCLES-1.
- Rise deasserts after edge k+STABLE_CYCLES.
- Latency from Din change to Level change is STABLE_CYCLES cycles, plus the upstream synchroniser's 2 cycles.
- Busy rises after edge k. It falls after the commit edge or after the abort edge.
- Any single opposite sample during qualification restarts qualification from zero.
- On the first edge after Resetn deasserts, the FSM evaluates Din normally starting from S_LOW.
- If Din=1 at that first edge, qualification of a rise starts there.
- No combinational path from any input to any output.

## Test plan
Run with STABLE_CYCLES=4, EVT_W=8.
1. **Reset values:** hold Resetn=0 with Din=1 -> Level=0, Rise=0, Fall=0, Busy=0, Count=0; release Resetn with Din=1 -> Level=1 after the 4th edge, Rise high for 1 cycle, Count=1.
2. **Clean rise and fall:** Din 0->1 held 10 cycles, then 1->0 -> Rise pulses once 4 cycles after the rise; Fall pulses once 4 cycles after the fall; Busy high 3 cycles each time; Count=1.
3. **Glitch rejection:** Din=1 for 3 samples, 0 for 1 sample, 1 for 3 samples, then 0 -> Level stays 0, no Rise, Busy drops on each abort, Count unchanged.
4. **Count wrap and Clear:**
   - 256 accepted rises -> Count goes 255->0.
   - Clear asserted on the same edge as a Rise -> Count=0 and Rise still pulses.
5. **Reset mid-operation:** assert Resetn=0 asynchronously (off-edge) when cnt=2 in S_CHK_LO, with Level=1 -> Level=0, Busy=0 immediately, no Fall pulse, Count=0.
6. **Bounce burst:** drive alternating 1/0 for 20 cycles, then steady 1 -> exactly one Rise, 4 cycles after the steady 1 begins; Level never toggles during the burst.
